// File: rtl/dbg_pkg.sv
// Shared definitions for the debug readout sequencer: mode codes, FSM states
// and the layout of the 64-bit display word.
package dbg_pkg;

    localparam logic [1:0] DBG_HOLD = 2'b00;
    localparam logic [1:0] DBG_AUTO = 2'b01;
    localparam logic [1:0] DBG_STEP = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAdv,
        StFetch
    } dbg_state_e;

    localparam int unsigned DBG_CH_LSB   = 56;
    localparam int unsigned DBG_ADDR_LSB = 40;
    localparam int unsigned DBG_DATA_LSB = 0;

    function automatic logic [63:0] dbg_pack_disp(input logic [7:0]  ch,
                                                  input logic [7:0]  addr,
                                                  input logic [31:0] data);
        logic [63:0] w_word;
        w_word = '0;
        w_word[DBG_CH_LSB +: 8]    = ch;
        w_word[DBG_ADDR_LSB +: 8]  = addr;
        w_word[DBG_DATA_LSB +: 32] = data;
        return w_word;
    endfunction

endpackage

// File: rtl/dbg_scan_seq_if.sv
// Read bus shared by the sequencer (master) and the debug sources (slave):
// one address/channel pair out, all channels' data words back.
interface dbg_scan_seq_if #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0]          rd_addr_o;
    logic [$clog2(CH_NUM)-1:0]  rd_ch_o;
    logic [CH_NUM*DATA_W-1:0]   rd_data_i;

    modport master (output rd_addr_o, output rd_ch_o, input rd_data_i);
    modport slave  (input rd_addr_o, input rd_ch_o, output rd_data_i);

endinterface

// File: rtl/dbg_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV enabled cycles,
// synchronous clear has priority over enable.
module dbg_tick_gen #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned      CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    assign o_tick = i_en && (r_cnt == CNT_MAX);

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en) begin
            w_cnt_d = o_tick ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/dbg_scan_seq.sv
// Debug readout sequencer: walks an address pointer through the selected
// source channel and latches each word into the 7-segment display word.
module dbg_scan_seq
    import dbg_pkg::*;
#(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode_i,
    input  logic [$clog2(CH_NUM)-1:0]  ch_sel_i,
    input  logic                       step_i,
    input  logic [CH_NUM*ADDR_W-1:0]   ch_last_i,
    dbg_scan_seq_if.master             rd_bus,
    output logic [63:0]                disp_data_o,
    output logic                       valid_o,
    output logic                       wrap_o
);

    localparam int unsigned CH_W = $clog2(CH_NUM);

    dbg_state_e        r_state, w_state_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic [CH_W-1:0]   r_ch, w_ch_d;
    logic [63:0]       r_disp, w_disp_d;
    logic              r_valid, w_valid_d;
    logic              r_wrap, w_wrap_d;
    logic              r_pend, w_pend_d;
    logic              r_step_prev;

    logic              w_switch, w_step_edge;
    logic              w_tick, w_tick_en, w_tick_clr;
    logic [ADDR_W-1:0] w_last [CH_NUM];
    logic [DATA_W-1:0] w_data [CH_NUM];

    for (genvar k = 0; k < CH_NUM; k++) begin : g_slice
        assign w_last[k] = ch_last_i[k*ADDR_W +: ADDR_W];
        assign w_data[k] = rd_bus.rd_data_i[k*DATA_W +: DATA_W];
    end

    assign w_switch    = (ch_sel_i != r_ch);
    assign w_step_edge = step_i & ~r_step_prev;
    assign w_tick_en   = (r_state == StWait) && (mode_i == DBG_AUTO);
    // Prescaler only runs while waiting in auto mode, so every WAIT starts at 0.
    assign w_tick_clr  = !w_tick_en || w_switch;

    dbg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_tick_clr),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_ch_d    = r_ch;
        w_pend_d  = r_pend;
        w_disp_d  = r_disp;
        w_valid_d = 1'b0;
        w_wrap_d  = 1'b0;

        // A fetch in progress always lands, even if a switch restarts the scan.
        if (r_state == StFetch) begin
            w_valid_d = 1'b1;
            w_disp_d  = dbg_pack_disp(8'(r_ch), 8'(r_addr), 32'(w_data[r_ch]));
        end

        if (w_switch) begin
            w_ch_d    = ch_sel_i;
            w_addr_d  = '0;
            w_state_d = StFetch;
        end else begin
            unique case (r_state)
                StIdle: begin
                    case (mode_i)
                        DBG_HOLD: w_state_d = StIdle;
                        DBG_AUTO: w_state_d = StWait;
                        DBG_STEP: begin
                            if (w_step_edge || r_pend) begin
                                w_state_d = StAdv;
                                w_pend_d  = 1'b0;
                            end
                        end
                        default: w_state_d = StIdle;
                    endcase
                end
                StWait: begin
                    if (mode_i != DBG_AUTO) begin
                        w_state_d = StIdle;
                    end else if (w_tick) begin
                        w_state_d = StAdv;
                    end
                end
                StAdv: begin
                    if (r_addr >= w_last[r_ch]) begin
                        w_addr_d = '0;
                        w_wrap_d = 1'b1;
                    end else begin
                        w_addr_d = r_addr + 1'b1;
                    end
                    w_state_d = StFetch;
                end
                StFetch: w_state_d = (mode_i == DBG_AUTO) ? StWait : StIdle;
                default: w_state_d = StIdle;
            endcase

            if ((r_state != StIdle) && (mode_i == DBG_STEP) && w_step_edge) begin
                w_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_ch        <= '0;
            r_disp      <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_pend      <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_ch        <= w_ch_d;
            r_disp      <= w_disp_d;
            r_valid     <= w_valid_d;
            r_wrap      <= w_wrap_d;
            r_pend      <= w_pend_d;
            r_step_prev <= step_i;
        end
    end

    assign rd_bus.rd_addr_o = r_addr;
    assign rd_bus.rd_ch_o   = r_ch;
    assign disp_data_o      = r_disp;
    assign valid_o          = r_valid;
    assign wrap_o           = r_wrap;

endmodule

// File: tb/tb_dbg_scan_seq.sv
// Randomised self-checking bench for dbg_scan_seq against a pointer/latency
// reference model and a synthetic per-channel source memory.
module tb_dbg_scan_seq;

    localparam int unsigned CH_NUM   = 4;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TICK_DIV = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [1:0]               mode;
    logic [1:0]               ch_sel;
    logic                     step;
    logic [CH_NUM*ADDR_W-1:0] ch_last;
    logic [CH_NUM*DATA_W-1:0] rd_data;
    logic [63:0]              disp;
    logic                     valid;
    logic                     wrap;
    logic [31:0]              salt;

    int          n_total = 0;
    int          n_bad   = 0;
    int          m_ch;
    logic [5:0]  m_addr;
    logic [5:0]  m_last [CH_NUM];

    dbg_scan_seq_if #(.CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dbg_scan_seq #(
        .CH_NUM   (CH_NUM),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode),
        .ch_sel_i    (ch_sel),
        .step_i      (step),
        .ch_last_i   (ch_last),
        .rd_bus      (bus),
        .disp_data_o (disp),
        .valid_o     (valid),
        .wrap_o      (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input logic [31:0] s, input int ch,
                                             input logic [5:0] a);
        return s ^ {4'(ch), 4'h0, 2'b00, a, 16'(32'(a) * 131 + 7)};
    endfunction

    function automatic logic [63:0] exp_disp(input logic [31:0] s, input int ch,
                                             input logic [5:0] a);
        return {8'(ch), 8'h00, 2'b00, a, 8'h00, ref_word(s, ch, a)};
    endfunction

    // Source memories: every channel answers the shared address combinationally.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            rd_data[k*DATA_W +: DATA_W] = ref_word(salt, k, bus.rd_addr_o);
        end
    end
    assign bus.rd_data_i = rd_data;

    always_comb begin
        ch_last = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            ch_last[k*ADDR_W +: ADDR_W] = m_last[k];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_adv(output logic wrapped);
        if (m_addr >= m_last[m_ch]) begin
            m_addr  = '0;
            wrapped = 1'b1;
        end else begin
            m_addr  = m_addr + 1'b1;
            wrapped = 1'b0;
        end
    endtask

    // Step edge in cycle t: address/wrap visible at t+2, display/valid at t+3.
    task automatic step_once(input string tag);
        logic w;
        model_adv(w);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check({tag, "_addr"}, bus.rd_addr_o, m_addr);
        check({tag, "_wrap"}, wrap, w);
        check({tag, "_early_valid"}, valid, 1'b0);
        tick();
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_disp"}, disp, exp_disp(salt, m_ch, m_addr));
        tick();
        tick();
    endtask

    task automatic switch_ch(input int ch);
        ch_sel = 2'(ch);
        tick();
        check("sw_ch", bus.rd_ch_o, ch);
        check("sw_addr", bus.rd_addr_o, 0);
        check("sw_wrap", wrap, 1'b0);
        m_ch   = ch;
        m_addr = '0;
        tick();
        check("sw_valid", valid, 1'b1);
        check("sw_disp", disp, exp_disp(salt, m_ch, m_addr));
        tick();
    endtask

    initial begin
        logic        w;
        int          last_v;
        int          nv;
        logic [63:0] last_disp;
        int          ch;

        salt   = $urandom;
        rst    = 1'b1;
        mode   = 2'b00;
        ch_sel = 2'd0;
        step   = 1'b0;
        m_ch   = 0;
        m_addr = '0;
        m_last[0] = 6'd3;
        for (int k = 1; k < CH_NUM; k++) m_last[k] = 6'($urandom_range(1, 7));
        tick();
        tick();
        check("rst_addr", bus.rd_addr_o, 0);
        check("rst_ch", bus.rd_ch_o, 0);
        check("rst_disp", disp, 0);
        check("rst_valid", valid, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        rst = 1'b0;
        tick();

        // Step mode on channel 0, last index 3: addresses 1,2,3,0.
        mode = 2'b10;
        tick();
        for (int i = 0; i < 4; i++) step_once("step");

        // Auto mode: first valid TICK_DIV+3 cycles after entry, then every TICK_DIV+2.
        mode   = 2'b01;
        last_v = 0;
        nv     = 0;
        for (int c = 1; c <= int'(TICK_DIV + 3 + 3 * (TICK_DIV + 2)); c++) begin
            tick();
            if (valid) begin
                model_adv(w);
                check("auto_gap", c - last_v, (nv == 0) ? TICK_DIV + 3 : TICK_DIV + 2);
                check("auto_disp", disp, exp_disp(salt, m_ch, m_addr));
                last_v = c;
                nv++;
            end
        end
        check("auto_count", nv, 4);

        // Channel switch in the same cycle as the auto tick: switch wins.
        repeat (TICK_DIV - 1) tick();
        ch_sel = 2'd2;
        tick();
        check("swt_ch", bus.rd_ch_o, 2);
        check("swt_addr", bus.rd_addr_o, 0);
        check("swt_wrap", wrap, 1'b0);
        check("swt_no_valid", valid, 1'b0);
        m_ch   = 2;
        m_addr = '0;
        tick();
        check("swt_valid", valid, 1'b1);
        check("swt_disp", disp, exp_disp(salt, 2, 6'd0));
        check("swt_addr_hold", bus.rd_addr_o, 0);
        tick();
        check("swt_no_adv", bus.rd_addr_o, 0);
        mode = 2'b00;
        tick();
        tick();

        // Channel 1 with last index 0: every step wraps back to 0.
        m_last[1] = 6'd0;
        switch_ch(1);
        mode = 2'b10;
        tick();
        for (int i = 0; i < 3; i++) step_once("last0");

        // Random channels, depths and step counts; depth may drop below pointer.
        for (int it = 0; it < 20; it++) begin
            ch = int'($urandom_range(0, CH_NUM - 1));
            if (ch != m_ch) switch_ch(ch);
            if ($urandom_range(0, 2) == 0) m_last[ch] = 6'($urandom_range(0, 7));
            for (int s = 0; s < int'($urandom_range(1, 5)); s++) step_once("rnd");
        end

        // Two step edges one cycle apart: second one is held pending.
        m_last[m_ch] = 6'd9;
        nv = 0;
        last_disp = '0;
        for (int c = 0; c < 10; c++) begin
            step = (c == 0 || c == 2);
            tick();
            if (valid) begin
                nv++;
                last_disp = disp;
            end
        end
        step = 1'b0;
        model_adv(w);
        model_adv(w);
        check("pend_count", nv, 2);
        check("pend_addr", bus.rd_addr_o, m_addr);
        check("pend_disp", last_disp, exp_disp(salt, m_ch, m_addr));

        // Reset asserted during FETCH clears all outputs immediately.
        if (m_ch != 0) switch_ch(0);
        m_last[0] = 6'd5;
        model_adv(w);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("prerst_addr", bus.rd_addr_o, m_addr);
        #1 rst = 1'b1;
        #1;
        check("midrst_addr", bus.rd_addr_o, 0);
        check("midrst_ch", bus.rd_ch_o, 0);
        check("midrst_disp", disp, 0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_wrap", wrap, 1'b0);
        tick();
        rst    = 1'b0;
        m_ch   = 0;
        m_addr = '0;
        nv     = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (valid) nv++;
        end
        check("postrst_valid", nv, 0);
        check("postrst_disp", disp, 0);
        check("postrst_addr", bus.rd_addr_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
